conv_frame_loader: RTL and testbench
====================================

# conv_frame_loader

Parametrised successor to the switch-driven 6x6 row loader feeding `convLayer`. It assembles a ROWS x COLS binary frame one row per strobe into a shadow buffer. On commit it transfers the completed frame into a double-buffered output register, presented to the convolution layer with a valid/ready handshake. It adds input synchronisation, edge detection, frame-complete checking, back-pressure with one pending commit, and sticky error flags, none of which the first-generation loader had.

## Interface
Parameters:
- COLS, default 6: row width in bits (1..32).
- ROWS, default 6: rows per frame (2..32).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- row_data  in  COLS  row value from switches. Not synchronised; must be stable from row_strobe rise until 3 cycles later.
- row_strobe  in  1  asynchronous level; each rising edge stores one row.
- commit  in  1  asynchronous level; each rising edge requests frame transfer.
- clear  in  1  asynchronous level; each rising edge aborts the fill.
- frame_out  out  ROWS*COLS  committed frame; row r at bits [r*COLS +: COLS].
- frame_valid  out  1  frame_out holds an unconsumed frame.
- frame_ready  in  1  consumer accepts the frame when high together with frame_valid.
- row_count  out  $clog2(ROWS+1)  rows stored in the shadow buffer.
- overflow  out  1  sticky; a strobe arrived while the shadow buffer was full.
- short_commit  out  1  sticky; a commit arrived while the shadow buffer was not full.

## Operation
- row_strobe, commit and clear each pass through a 2-FF synchroniser and then a rising-edge detector, producing a 1-cycle pulse (stb_p, cmt_p, clr_p).
- FSM states:
  - FILL: row_count < ROWS.
  - FULL: row_count == ROWS, no commit pending.
  - PEND: full, commit accepted, output still occupied.
- stb_p in FILL: shadow[row_count] <= row_data; row_count++. On reaching ROWS, go to FULL.
- stb_p in FULL or PEND: ignored; overflow <= 1.
- cmt_p in FILL: ignored; short_commit <= 1.
- cmt_p in FULL, output free (frame_valid==0, or frame_valid && frame_ready this cycle): frame_out <= shadow; frame_valid <= 1; row_count <= 0; go to FILL.
- cmt_p in FULL, output occupied: go to PEND.
- PEND: transfer happens on the cycle frame_valid && frame_ready; frame_valid stays 1 with new data; row_count <= 0; go to FILL.
- cmt_p in PEND: no effect.
- Handshake: frame_out and frame_valid are held while frame_valid && !frame_ready. On acceptance with no transfer, frame_valid <= 0 at the next edge.
- clr_p: row_count <= 0; overflow, short_commit <= 0; go to FILL; a pending commit is dropped. Shadow contents are not zeroed. frame_out and frame_valid are unaffected.
- Priority within one cycle: clr_p > cmt_p > stb_p for state decisions. Each pulse is evaluated against pre-edge state. stb_p and cmt_p together with row_count == ROWS-1: the row is written, FSM goes to FULL, short_commit is set, and no transfer happens.
- Async reset values: row_count 0, state FILL, frame_valid 0, frame_out 0, overflow 0, short_commit 0, synchroniser and edge flops 0. Shadow buffer is reset to 0.

## Timing
- Input rise sampled at edge k: sync1 at k, sync2 at k+1, pulse during cycle k+1..k+2, action at edge k+2.
- Strobe: row_count and shadow update at edge k+2. row_data is captured at edge k+2.
- Commit (output free): frame_valid = 1 and frame_out valid after edge k+2.
- Consumer: accept at edge j with no reload gives frame_valid = 0 after edge j. A PEND reload is visible after edge j.
- Minimum strobe spacing is 2 cycles low plus 2 cycles high. Narrower pulses may be lost, which is acceptable.
- No combinational path from any input to any output.

## Structure
- Shared package `conv_pkg`:
  - default COLS/ROWS constants;
  - `loader_state_t` enum {FILL, FULL, PEND};
  - count-width function used by `convLayer` and this block.
- Sub-module `sync_edge_detect` (2-FF sync + rising-edge pulse, async reset), instantiated three times.
- Shadow buffer and output register: flat ROWS*COLS vectors, no memory macro.

## Test plan
- Default params. Six strobes with rows 0x3F, 0x21, 0x12, 0x0C, 0x15, 0x2A, then commit with frame_ready=1 → frame_out = {0x2A,0x15,0x0C,0x12,0x21,0x3F} (row 0 in LSBs); frame_valid high 1 cycle; row_count 0.
- Strobe rises at edge k → row_count goes 0→1 after edge k+2 exactly. A 1-cycle-wide strobe glitch with 1-cycle spacing is not double-counted.
- Four strobes, then commit → no transfer; short_commit=1; row_count=4. Clear → row_count=0; short_commit=0.
- Full buffer, 7th strobe → overflow=1; row_count stays 6; shadow[5] unchanged.
- frame_ready=0 with frame A held; refill frame B, commit → state PEND, frame_out still A. Raise frame_ready → frame_out=B the next cycle; frame_valid never drops.
- Reset asserted mid-fill at row_count=3 with frame_valid=1 → all outputs 0 immediately. After release, the first strobe goes to row 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front-end: default frame geometry,
// loader FSM states and the counter-width helper.
package conv_pkg;
  localparam int unsigned DEFAULT_COLS = 6;
  localparam int unsigned DEFAULT_ROWS = 6;

  typedef enum logic [1:0] {FILL, FULL, PEND} loader_state_t;

  function automatic int unsigned count_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/conv_frame_loader_if.sv
// Frame hand-off channel between the loader (master) and convLayer (slave).
interface conv_frame_loader_if
  import conv_pkg::*;
#(
  parameter int unsigned COLS = DEFAULT_COLS,
  parameter int unsigned ROWS = DEFAULT_ROWS
) ();
  logic [ROWS*COLS-1:0] frame_out;
  logic                 frame_valid;
  logic                 frame_ready;

  modport master (output frame_out, output frame_valid, input frame_ready);
  modport slave  (input frame_out, input frame_valid, output frame_ready);
endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge
// detector; emits a one-cycle pulse per synchronised rise.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);
  logic s1, s2, prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= level;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign rise = s2 & ~prev;
endmodule

// File: rtl/conv_frame_loader.sv
// Row-per-strobe frame assembler with a shadow buffer, one pending commit and
// a valid/ready output register feeding convLayer.
module conv_frame_loader
  import conv_pkg::*;
#(
  parameter int unsigned COLS = DEFAULT_COLS,
  parameter int unsigned ROWS = DEFAULT_ROWS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [COLS-1:0]               row_data,
  input  logic                          row_strobe,
  input  logic                          commit,
  input  logic                          clear,
  conv_frame_loader_if.master           frm,
  output logic [count_width(ROWS)-1:0]  row_count,
  output logic                          overflow,
  output logic                          short_commit
);
  localparam int unsigned CW = count_width(ROWS);
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  logic stb_p, cmt_p, clr_p;

  sync_edge_detect u_stb (.clk(clk), .rst_n(rst_n), .level(row_strobe), .rise(stb_p));
  sync_edge_detect u_cmt (.clk(clk), .rst_n(rst_n), .level(commit),     .rise(cmt_p));
  sync_edge_detect u_clr (.clk(clk), .rst_n(rst_n), .level(clear),      .rise(clr_p));

  loader_state_t        state, state_n;
  logic [CW-1:0]        count_n;
  logic [ROWS*COLS-1:0] shadow, shadow_n;
  logic [ROWS*COLS-1:0] frame_q, frame_n;
  logic                 valid_q, valid_n;
  logic                 overflow_n, short_n;
  logic                 accept, transfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= FILL;
      row_count    <= '0;
      shadow       <= '0;
      frame_q      <= '0;
      valid_q      <= 1'b0;
      overflow     <= 1'b0;
      short_commit <= 1'b0;
    end else begin
      state        <= state_n;
      row_count    <= count_n;
      shadow       <= shadow_n;
      frame_q      <= frame_n;
      valid_q      <= valid_n;
      overflow     <= overflow_n;
      short_commit <= short_n;
    end
  end

  always_comb begin
    state_n    = state;
    count_n    = row_count;
    shadow_n   = shadow;
    frame_n    = frame_q;
    valid_n    = valid_q;
    overflow_n = overflow;
    short_n    = short_commit;
    transfer   = 1'b0;
    accept     = valid_q & frm.frame_ready;

    if (accept) valid_n = 1'b0;

    // Clear preempts strobe and commit outright, including a pending transfer.
    if (clr_p) begin
      count_n    = '0;
      overflow_n = 1'b0;
      short_n    = 1'b0;
      state_n    = FILL;
    end else begin
      case (state)
        FILL: begin
          if (stb_p) begin
            for (int unsigned r = 0; r < ROWS; r++)
              if (row_count == CW'(r)) shadow_n[r*COLS +: COLS] = row_data;
            count_n = row_count + 1'b1;
            if (row_count == LAST_ROW) state_n = FULL;
          end
          if (cmt_p) short_n = 1'b1;
        end
        FULL: begin
          if (stb_p) overflow_n = 1'b1;
          if (cmt_p) begin
            if (!valid_q || frm.frame_ready) transfer = 1'b1;
            else                             state_n  = PEND;
          end
        end
        PEND: begin
          if (stb_p)  overflow_n = 1'b1;
          if (accept) transfer   = 1'b1;
        end
        default: state_n = FILL;
      endcase
    end

    // A transfer overrides the accept-driven drop, so valid never dips on reload.
    if (transfer) begin
      frame_n = shadow;
      valid_n = 1'b1;
      count_n = '0;
      state_n = FILL;
    end
  end

  assign frm.frame_out   = frame_q;
  assign frm.frame_valid = valid_q;
endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed bench for conv_frame_loader at default 6x6 geometry.
module tb_conv_frame_loader;
  localparam int unsigned COLS = 6;
  localparam int unsigned ROWS = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [COLS-1:0] row_data = '0;
  logic            row_strobe = 1'b0;
  logic            commit = 1'b0;
  logic            clear = 1'b0;
  logic [2:0]      row_count;
  logic            overflow, short_commit;

  int vectors = 0;
  int miscompares = 0;

  conv_frame_loader_if #(.COLS(COLS), .ROWS(ROWS)) frm ();

  conv_frame_loader #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_strobe(row_strobe),
    .commit(commit), .clear(clear), .frm(frm), .row_count(row_count),
    .overflow(overflow), .short_commit(short_commit)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [COLS-1:0] v);
    row_data = v; row_strobe = 1'b1; tick(3);
    row_strobe = 1'b0; tick(3);
  endtask

  task automatic commit_rise();
    commit = 1'b1; tick(3);
  endtask

  task automatic commit_fall();
    commit = 1'b0; tick(3);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(3);
    clear = 1'b0; tick(3);
  endtask

  function automatic logic [35:0] mk(input logic [5:0] r0, r1, r2, r3, r4, r5);
    return {r5, r4, r3, r2, r1, r0};
  endfunction

  initial begin
    frm.frame_ready = 1'b0;
    tick(2);
    chk("rst_valid", frm.frame_valid, 0);
    chk("rst_frame", frm.frame_out, 0);
    chk("rst_count", row_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_short", short_commit, 0);
    rst_n = 1'b1;
    tick(2);

    // strobe latency: rise sampled at edge k, count moves at k+2
    row_data = 6'h3F; row_strobe = 1'b1;
    tick(1);
    tick(1);
    chk("lat_k1", row_count, 0);
    tick(1);
    chk("lat_k2", row_count, 1);
    row_strobe = 1'b0; tick(3);
    strobe(6'h21); strobe(6'h12); strobe(6'h0C); strobe(6'h15); strobe(6'h2A);
    chk("full_count", row_count, 6);

    frm.frame_ready = 1'b1;
    commit_rise();
    chk("c1_valid", frm.frame_valid, 1);
    chk("c1_frame", frm.frame_out, mk(6'h3F, 6'h21, 6'h12, 6'h0C, 6'h15, 6'h2A));
    chk("c1_count", row_count, 0);
    tick(1);
    chk("c1_valid_drop", frm.frame_valid, 0);
    commit = 1'b0; tick(3);

    // single-cycle strobe counts once
    row_data = 6'h07; row_strobe = 1'b1; tick(1);
    row_strobe = 1'b0; tick(5);
    chk("glitch_count", row_count, 1);
    strobe(6'h01); strobe(6'h02); strobe(6'h03);
    commit_rise(); commit_fall();
    chk("short_flag", short_commit, 1);
    chk("short_count", row_count, 4);
    chk("short_valid", frm.frame_valid, 0);
    do_clear();
    chk("clr_count", row_count, 0);
    chk("clr_short", short_commit, 0);

    // overflow leaves row 5 alone
    strobe(6'h01); strobe(6'h02); strobe(6'h04); strobe(6'h08); strobe(6'h10); strobe(6'h20);
    strobe(6'h3F);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", row_count, 6);
    commit_rise();
    chk("ovf_frame", frm.frame_out, mk(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20));
    commit_fall();
    do_clear();
    chk("clr_ovf", overflow, 0);

    // back-pressure: frame A held, frame B pending
    frm.frame_ready = 1'b0;
    strobe(6'h11); strobe(6'h12); strobe(6'h13); strobe(6'h14); strobe(6'h15); strobe(6'h16);
    commit_rise(); commit_fall();
    chk("A_valid", frm.frame_valid, 1);
    chk("A_frame", frm.frame_out, mk(6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16));
    strobe(6'h21); strobe(6'h22); strobe(6'h23); strobe(6'h24); strobe(6'h25); strobe(6'h26);
    commit_rise(); commit_fall();
    chk("pend_state", dut.state, 2);
    chk("pend_frame", frm.frame_out, mk(6'h11, 6'h12, 6'h13, 6'h14, 6'h15, 6'h16));
    chk("pend_count", row_count, 6);
    frm.frame_ready = 1'b1;
    tick(1);
    chk("B_valid", frm.frame_valid, 1);
    chk("B_frame", frm.frame_out, mk(6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26));
    chk("B_count", row_count, 0);
    tick(1);
    chk("B_valid_drop", frm.frame_valid, 0);

    // async reset mid-fill with a held frame
    frm.frame_ready = 1'b0;
    strobe(6'h31); strobe(6'h32); strobe(6'h33); strobe(6'h34); strobe(6'h35); strobe(6'h36);
    commit_rise(); commit_fall();
    strobe(6'h01); strobe(6'h02); strobe(6'h03);
    chk("pre_rst_count", row_count, 3);
    chk("pre_rst_valid", frm.frame_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_count", row_count, 0);
    chk("arst_valid", frm.frame_valid, 0);
    chk("arst_frame", frm.frame_out, 0);
    #2;
    rst_n = 1'b1;
    tick(2);
    frm.frame_ready = 1'b1;
    strobe(6'h2A); strobe(6'h01); strobe(6'h02); strobe(6'h03); strobe(6'h04); strobe(6'h05);
    commit_rise();
    chk("post_rst_frame", frm.frame_out, mk(6'h2A, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05));
    commit_fall();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
